mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one single-ported unified memory between the instruction-fetch port and the MEM-stage data port of the 5-stage RISC-V pipeline. Requests are arbitrated with data priority and a bounded fetch-starvation guard. The block issues one memory transaction at a time and returns acknowledge and read data. It also drives the IF and MEM stall signals consumed by the pipeline-register enables.

Parameters:
PC_W, 9, fetch address width
DM_ADDRESS, 9, data/memory address width (PC_W <= DM_ADDRESS)
DATA_W, 32, data width
MAX_STREAK, 4, consecutive data grants allowed while fetch is pending
TIMEOUT, 16, cycles to wait for m_rvalid before aborting

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
if_req  in  1  fetch request, held until if_ack
if_addr  in  PC_W  fetch address
if_ack  out  1  fetch complete pulse
if_rdata  out  DATA_W  instruction word, valid with if_ack
d_req  in  1  data request (MemRead|MemWrite), held until d_ack
d_we  in  1  1 = store
d_addr  in  DM_ADDRESS  data address
d_wdata  in  DATA_W  store data
d_funct3  in  3  access size/sign
d_ack  out  1  data complete pulse
d_rdata  out  DATA_W  load data, valid with d_ack
m_req  out  1  one-cycle issue strobe to memory
m_we  out  1  write enable
m_addr  out  DM_ADDRESS  latched address
m_wdata  out  DATA_W  latched store data
m_funct3  out  3  latched funct3 (3'b010 for fetch)
m_rvalid  in  1  memory completion, reads and writes
m_rdata  in  DATA_W  memory read data
if_stall  out  1  if_req & ~if_ack
mem_stall  out  1  d_req & ~d_ack
err  out  1  sticky timeout flag

Behaviour:
- States: IDLE, ISSUE_I, WAIT_I, ISSUE_D, WAIT_D.
- IDLE: grant D if d_req && (streak < MAX_STREAK || !if_req); else grant I if if_req; else stay.
- On grant, latch address, wdata, we and funct3 into the m_* registers, then go to ISSUE_x.
- Fetch latches: we=0, funct3=010, address zero-extended.
- ISSUE_x: m_req=1 for exactly one cycle, then go to WAIT_x. Timeout counter is cleared.
- WAIT_x: m_req=0. When m_rvalid=1, pulse x_ack combinationally in the same cycle, drive x_rdata=m_rdata, and go to IDLE.
- When d_we=1, d_rdata is don't-care and the bench drives it to 0.
- Latency: request seen in IDLE at cycle 0 -> m_req at cycle 1 -> ack at cycle 1+L, where L is the memory latency (>=1).
- Back-to-back transactions: at least one IDLE cycle between them, so sustained throughput is 1 transaction per L+2 cycles.
- Streak counter (width clog2(MAX_STREAK+1)):
  - increments on a D grant while if_req=1;
  - clears on an I grant or whenever if_req=0 in IDLE;
  - saturates at MAX_STREAK.
- Timeout: in WAIT_x the counter increments each cycle. If it reaches TIMEOUT-1 without m_rvalid:
  - go to IDLE, set err=1 (sticky until reset);
  - assert x_ack with x_rdata=0 so the pipeline does not deadlock.
- m_rvalid outside WAIT_x (stray or late) is ignored and does not change state.
- Requester changing address while its req is held is illegal; the latched copy is used.
- Simultaneous d_req and if_req with streak < MAX_STREAK: data wins.
- Reset values, asserted at any state including mid-transaction:
  - state=IDLE; streak=0; timeout=0; err=0;
  - m_req=0, m_we=0, m_addr=0, m_wdata=0, m_funct3=0;
  - if_ack=0, d_ack=0, if_rdata=0, d_rdata=0.
  - A response arriving after reset is ignored.
- if_stall and mem_stall are combinational from req/ack.

Decomposition:
- Pipe_Buf_Reg_PKG gains:
  - arb_state_t enum (IDLE, ISSUE_I, WAIT_I, ISSUE_D, WAIT_D);
  - mem_txn_t struct (we, addr, wdata, funct3);
  - constant FETCH_FUNCT3 = 3'b010.
- One sub-module, arb_timeout_ctr: loadable counter with clear and expire output, parameterised by TIMEOUT.

Test Plan:
- Fetch only, L=2: if_req=1, if_addr=0x004 -> m_req at cycle 1 with m_addr=0x004, we=0, funct3=010; rvalid at cycle 3 with rdata=0x00500093 -> if_ack and if_rdata=0x00500093 at cycle 3; if_stall=1 in cycles 0-2.
- Simultaneous if_req and d_req (store, addr 0x010, wdata 0xDEADBEEF): data issued first with m_we=1; fetch issued in the IDLE->ISSUE_I sequence after d_ack; mem_stall drops in the d_ack cycle.
- Starvation, MAX_STREAK=4: d_req held high continuously, if_req held high -> 4 data grants, then 1 fetch grant, then data resumes.
- Timeout: no m_rvalid for 16 cycles in WAIT_D -> d_ack with d_rdata=0, err=1; a stray m_rvalid in the next IDLE cycle is ignored and err stays 1.
- Reset mid-WAIT_I: reset for 1 cycle -> all outputs 0, state IDLE; late m_rvalid produces no if_ack.
- Load after store, same address 0x020: store 0x12345678, then load with funct3=010 -> d_rdata=0x12345678; m_req pulses exactly one cycle per transaction.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
//
// Shared types and constants for the unified-memory port arbiter that sits
// between the IF stage (instruction fetch) and the MEM stage (loads/stores)
// of the 5-stage RISC-V pipeline.
//
// Contents:
//   ARB_ADDR_W / ARB_DATA_W : widths of the latched transaction fields; the
//                             arbiter's address/data parameters default to
//                             these, and values wider than them are truncated
//                             when the transaction is latched.
//   FETCH_FUNCT3            : access size used for every instruction fetch
//                             (word access).
//   arb_state_t             : arbiter FSM states.
//   mem_txn_t               : one latched memory transaction.
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    localparam int ARB_ADDR_W = 9;
    localparam int ARB_DATA_W = 32;

    // Instruction fetches are always full-word accesses.
    localparam logic [2:0] FETCH_FUNCT3 = 3'b010;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE_I = 3'd1,
        WAIT_I  = 3'd2,
        ISSUE_D = 3'd3,
        WAIT_D  = 3'd4
    } arb_state_t;

    typedef struct packed {
        logic                  we;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
        logic [2:0]            funct3;
    } mem_txn_t;

endpackage

// File: rtl/mem_port_arbiter_timeout_ctr.sv
// -----------------------------------------------------------------------------
// arb_timeout_ctr
//
// Loadable up-counter used to bound how long the arbiter waits for a memory
// completion. The count saturates at TIMEOUT-1, at which point expire is held
// high until the counter is cleared or reloaded.
//
// Ports:
//   clk        : clock
//   reset      : synchronous, active-high; clears the count
//   clear      : synchronous clear (takes priority over load/en)
//   load       : load load_value into the count
//   load_value : value loaded when load is high
//   en         : count enable
//   expire     : high while the count equals TIMEOUT-1
// -----------------------------------------------------------------------------
module arb_timeout_ctr
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 16,
    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             en,
    output logic             expire
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    assign expire = (count_reg == LAST);

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (load) begin
            count_next = load_value;
        end else if (en && !expire) begin
            // Hold at the terminal value so expire cannot wrap back to low.
            count_next = count_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported unified memory between the instruction-fetch port
// (I) and the MEM-stage data port (D). One transaction is in flight at a time:
//   IDLE -> ISSUE_x (one-cycle m_req strobe) -> WAIT_x (until m_rvalid) -> IDLE
// Data has priority, but after MAX_STREAK consecutive data grants taken while
// a fetch was pending, the next grant goes to the fetch. A missing completion
// is bounded by TIMEOUT: the requester is acknowledged with zero data and the
// sticky err flag is raised so the pipeline never deadlocks.
//
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   if_req/if_addr        : fetch request (held until if_ack) and address
//   if_ack/if_rdata       : fetch completion pulse and instruction word
//   d_req/d_we/d_addr     : data request (held until d_ack), store flag, address
//   d_wdata/d_funct3      : store data and access size/sign
//   d_ack/d_rdata         : data completion pulse and load data
//   m_req                 : one-cycle issue strobe to the memory
//   m_we/m_addr/m_wdata   : latched transaction towards the memory
//   m_funct3              : latched access size (word for fetches)
//   m_rvalid/m_rdata      : memory completion (reads and writes) and read data
//   if_stall/mem_stall    : stage stalls, request outstanding and not yet acked
//   err                   : sticky timeout flag, cleared only by reset
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int PC_W       = ARB_ADDR_W,
    parameter int DM_ADDRESS = ARB_ADDR_W,
    parameter int DATA_W     = ARB_DATA_W,
    parameter int MAX_STREAK = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  if_req,
    input  logic [PC_W-1:0]       if_addr,
    output logic                  if_ack,
    output logic [DATA_W-1:0]     if_rdata,

    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DM_ADDRESS-1:0] d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [2:0]            d_funct3,
    output logic                  d_ack,
    output logic [DATA_W-1:0]     d_rdata,

    output logic                  m_req,
    output logic                  m_we,
    output logic [DM_ADDRESS-1:0] m_addr,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [2:0]            m_funct3,
    input  logic                  m_rvalid,
    input  logic [DATA_W-1:0]     m_rdata,

    output logic                  if_stall,
    output logic                  mem_stall,
    output logic                  err
);

    localparam int STREAK_W = $clog2(MAX_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

    arb_state_t          state_reg;
    arb_state_t          state_next;
    mem_txn_t            txn_reg;
    mem_txn_t            txn_next;
    logic [STREAK_W-1:0] streak_reg;
    logic [STREAK_W-1:0] streak_next;
    logic                err_reg;
    logic                err_next;

    logic                streak_full;
    logic                wait_state;
    logic                wait_done;
    logic                tmo_expire;

    // -------------------------------------------------------------------------
    // Completion timeout: the counter runs only while waiting for m_rvalid and
    // is held at zero otherwise, so every WAIT_x starts counting from zero.
    // -------------------------------------------------------------------------
    assign wait_state = (state_reg == WAIT_I) || (state_reg == WAIT_D);

    arb_timeout_ctr #(
        .TIMEOUT    (TIMEOUT)
    ) u_timeout (
        .clk        (clk),
        .reset      (reset),
        .clear      (!wait_state),
        .load       (1'b0),
        .load_value ('0),
        .en         (wait_state),
        .expire     (tmo_expire)
    );

    // A real completion wins over a simultaneous expiry.
    assign wait_done   = wait_state && (m_rvalid || tmo_expire);
    assign streak_full = (streak_reg >= STREAK_MAX);

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        txn_next    = txn_reg;
        streak_next = streak_reg;
        err_next    = err_reg;
        m_req       = 1'b0;
        if_ack      = 1'b0;
        d_ack       = 1'b0;
        if_rdata    = '0;
        d_rdata     = '0;

        case (state_reg)
            IDLE: begin
                if (d_req && (!streak_full || !if_req)) begin
                    state_next      = ISSUE_D;
                    txn_next.we     = d_we;
                    txn_next.addr   = ARB_ADDR_W'(d_addr);
                    txn_next.wdata  = ARB_DATA_W'(d_wdata);
                    txn_next.funct3 = d_funct3;
                    // A data grant with a fetch pending can only happen while
                    // the streak is below its limit, so the increment never
                    // overshoots MAX_STREAK. With no fetch pending the streak
                    // restarts from zero.
                    streak_next     = if_req ? (streak_reg + STREAK_W'(1)) : '0;
                end else if (if_req) begin
                    state_next      = ISSUE_I;
                    txn_next.we     = 1'b0;
                    txn_next.addr   = ARB_ADDR_W'(if_addr);
                    txn_next.wdata  = '0;
                    txn_next.funct3 = FETCH_FUNCT3;
                    streak_next     = '0;
                end else begin
                    streak_next     = '0;
                end
            end

            ISSUE_I: begin
                m_req      = 1'b1;
                state_next = WAIT_I;
            end

            ISSUE_D: begin
                m_req      = 1'b1;
                state_next = WAIT_D;
            end

            WAIT_I, WAIT_D: begin
                if (wait_done) begin
                    state_next = IDLE;
                    // Reaching here without m_rvalid means the memory never
                    // answered: acknowledge with zero data and flag it.
                    if (!m_rvalid) begin
                        err_next = 1'b1;
                    end
                    if (state_reg == WAIT_I) begin
                        if_ack   = 1'b1;
                        if_rdata = m_rvalid ? m_rdata : '0;
                    end else begin
                        d_ack    = 1'b1;
                        d_rdata  = m_rvalid ? m_rdata : '0;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            txn_reg    <= '0;
            streak_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            txn_reg    <= txn_next;
            streak_reg <= streak_next;
            err_reg    <= err_next;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign m_we      = txn_reg.we;
    assign m_addr    = DM_ADDRESS'(txn_reg.addr);
    assign m_wdata   = DATA_W'(txn_reg.wdata);
    assign m_funct3  = txn_reg.funct3;
    assign err       = err_reg;

    assign if_stall  = if_req & ~if_ack;
    assign mem_stall = d_req & ~d_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter. Inputs change only just after the
// falling clock edge; outputs are sampled 1 time unit later. A transaction-
// level model (who owns the memory and how many cycles since the grant) gives
// the expected outputs for every cycle. A small memory model answers issues
// with a chosen latency. Directed scenarios add literal expectations; a
// randomized phase follows.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int PC_W       = 9;
    localparam int DM_ADDRESS = 9;
    localparam int DATA_W     = 32;
    localparam int MAX_STREAK = 4;
    localparam int TIMEOUT    = 16;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  if_req = 1'b0;
    logic [PC_W-1:0]       if_addr = '0;
    logic                  if_ack;
    logic [DATA_W-1:0]     if_rdata;
    logic                  d_req = 1'b0;
    logic                  d_we = 1'b0;
    logic [DM_ADDRESS-1:0] d_addr = '0;
    logic [DATA_W-1:0]     d_wdata = '0;
    logic [2:0]            d_funct3 = '0;
    logic                  d_ack;
    logic [DATA_W-1:0]     d_rdata;
    logic                  m_req;
    logic                  m_we;
    logic [DM_ADDRESS-1:0] m_addr;
    logic [DATA_W-1:0]     m_wdata;
    logic [2:0]            m_funct3;
    logic                  m_rvalid = 1'b0;
    logic [DATA_W-1:0]     m_rdata = '0;
    logic                  if_stall;
    logic                  mem_stall;
    logic                  err;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .PC_W       (PC_W),
        .DM_ADDRESS (DM_ADDRESS),
        .DATA_W     (DATA_W),
        .MAX_STREAK (MAX_STREAK),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_funct3  (d_funct3),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .m_req     (m_req),
        .m_we      (m_we),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_funct3  (m_funct3),
        .m_rvalid  (m_rvalid),
        .m_rdata   (m_rdata),
        .if_stall  (if_stall),
        .mem_stall (mem_stall),
        .err       (err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    bit                    mb_busy;        // a transaction owns the memory
    int                    mb_step;        // 1 = issue cycle, >=2 = waiting
    bit                    mb_is_d;
    bit                    mb_we;
    logic [DM_ADDRESS-1:0] mb_addr;
    logic [DATA_W-1:0]     mb_wdata;
    bit                    mb_wdata_known; // fetch leaves the data field unspecified
    logic [2:0]            mb_f3;
    int                    mb_streak;
    bit                    mb_err;
    bit                    saw_if_ack, saw_d_ack, saw_mreq;

    // ---------------- memory model ----------------
    logic [DATA_W-1:0]     mem [512];
    bit                    auto_mem = 1'b0;
    bit                    stray_en = 1'b0;
    bit                    late_en = 1'b0;
    int                    lat_min = 1, lat_max = 1;
    int                    cd = 0;
    bit                    cd_we;
    logic [DM_ADDRESS-1:0] cd_addr;

    task automatic model_reset();
        mb_busy = 0; mb_step = 0; mb_is_d = 0; mb_we = 0;
        mb_addr = '0; mb_wdata = '0; mb_wdata_known = 1; mb_f3 = '0;
        mb_streak = 0; mb_err = 0;
    endtask

    task automatic mem_drive();
        m_rvalid = 1'b0;
        m_rdata  = '0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                m_rvalid = 1'b1;
                m_rdata  = cd_we ? '0 : mem[cd_addr];
            end
        end else if (stray_en && $urandom_range(0, 15) == 0) begin
            m_rvalid = 1'b1;
            m_rdata  = $urandom;
        end
    endtask

    // Compare this cycle's outputs against the model, then advance the model.
    task automatic cycle_check();
        bit waiting, done;
        logic [DATA_W-1:0] e_rd;
        #1;
        waiting    = mb_busy && (mb_step >= 2);
        done       = waiting && (m_rvalid || (mb_step - 2 >= TIMEOUT - 1));
        e_rd       = (done && m_rvalid) ? m_rdata : '0;
        saw_mreq   = mb_busy && (mb_step == 1);
        saw_if_ack = done && !mb_is_d;
        saw_d_ack  = done && mb_is_d;

        chk("m_req",     32'(m_req),     32'(saw_mreq));
        chk("if_ack",    32'(if_ack),    32'(saw_if_ack));
        chk("d_ack",     32'(d_ack),     32'(saw_d_ack));
        chk("if_rdata",  if_rdata,       saw_if_ack ? e_rd : 32'd0);
        chk("d_rdata",   d_rdata,        saw_d_ack ? e_rd : 32'd0);
        chk("if_stall",  32'(if_stall),  32'(if_req && !saw_if_ack));
        chk("mem_stall", 32'(mem_stall), 32'(d_req && !saw_d_ack));
        chk("m_we",      32'(m_we),      32'(mb_we));
        chk("m_addr",    32'(m_addr),    32'(mb_addr));
        chk("m_funct3",  32'(m_funct3),  32'(mb_f3));
        chk("err",       32'(err),       32'(mb_err));
        if (mb_wdata_known) chk("m_wdata", m_wdata, mb_wdata);

        if (auto_mem && saw_mreq) begin
            if (mb_we) mem[mb_addr] = mb_wdata;
            cd_we   = mb_we;
            cd_addr = mb_addr;
            cd = (late_en && $urandom_range(0, 39) == 0) ? int'($urandom_range(17, 22))
                                                          : int'($urandom_range(lat_min, lat_max));
        end
        if (done && m_rvalid) cd = 0;

        if (reset) begin
            model_reset();
        end else if (waiting) begin
            if (done) begin
                mb_busy = 0;
                if (!m_rvalid) mb_err = 1;
            end else begin
                mb_step++;
            end
        end else if (mb_busy) begin
            mb_step = 2;
        end else if (d_req && (mb_streak < MAX_STREAK || !if_req)) begin
            mb_busy = 1; mb_step = 1; mb_is_d = 1;
            mb_we = d_we; mb_addr = d_addr; mb_wdata = d_wdata; mb_f3 = d_funct3;
            mb_wdata_known = 1;
            mb_streak = if_req ? ((mb_streak + 1 > MAX_STREAK) ? MAX_STREAK : mb_streak + 1) : 0;
        end else if (if_req) begin
            mb_busy = 1; mb_step = 1; mb_is_d = 0;
            mb_we = 0; mb_addr = DM_ADDRESS'(if_addr); mb_f3 = 3'b010;
            mb_wdata_known = 0;
            mb_streak = 0;
        end else begin
            mb_streak = 0;
        end
    endtask

    initial begin
        bit exp_pat [6];
        bit got_pat [6];
        int n_grant, issue_c, ack_c, phase, mreq_cnt;
        logic [DATA_W-1:0] ack_rd, got_rd;

        exp_pat = '{1, 1, 1, 1, 0, 1};
        for (int i = 0; i < 512; i++) mem[i] = $urandom;
        model_reset();

        // ---- reset state ----
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst m_req",    32'(m_req),    32'd0);
        chk("rst m_we",     32'(m_we),     32'd0);
        chk("rst m_addr",   32'(m_addr),   32'd0);
        chk("rst m_wdata",  m_wdata,       32'd0);
        chk("rst m_funct3", 32'(m_funct3), 32'd0);
        chk("rst if_ack",   32'(if_ack),   32'd0);
        chk("rst d_ack",    32'(d_ack),    32'd0);
        chk("rst if_rdata", if_rdata,      32'd0);
        chk("rst d_rdata",  d_rdata,       32'd0);
        chk("rst err",      32'(err),      32'd0);

        // ---- fetch only, L=2 ----
        @(negedge clk); reset = 0; if_req = 1; if_addr = 9'h004; cycle_check();
        chk("fetch c0 if_stall", 32'(if_stall), 32'd1);
        @(negedge clk); cycle_check();
        chk("fetch c1 m_req", 32'(m_req), 32'd1);
        chk("fetch c1 m_addr", 32'(m_addr), 32'h004);
        chk("fetch c1 m_we", 32'(m_we), 32'd0);
        chk("fetch c1 m_funct3", 32'(m_funct3), 32'd2);
        chk("fetch c1 if_stall", 32'(if_stall), 32'd1);
        @(negedge clk); cycle_check();
        chk("fetch c2 m_req", 32'(m_req), 32'd0);
        chk("fetch c2 if_stall", 32'(if_stall), 32'd1);
        @(negedge clk); m_rvalid = 1; m_rdata = 32'h00500093; cycle_check();
        chk("fetch c3 if_ack", 32'(if_ack), 32'd1);
        chk("fetch c3 if_rdata", if_rdata, 32'h00500093);
        chk("fetch c3 if_stall", 32'(if_stall), 32'd0);
        @(negedge clk); if_req = 0; m_rvalid = 0; m_rdata = '0; cycle_check();
        chk("fetch c4 if_ack", 32'(if_ack), 32'd0);

        // ---- simultaneous store and fetch ----
        @(negedge clk);
        if_req = 1; if_addr = 9'h008;
        d_req = 1; d_we = 1; d_addr = 9'h010; d_wdata = 32'hDEADBEEF; d_funct3 = 3'b010;
        cycle_check();
        @(negedge clk); cycle_check();
        chk("both c1 m_req", 32'(m_req), 32'd1);
        chk("both c1 m_we", 32'(m_we), 32'd1);
        chk("both c1 m_addr", 32'(m_addr), 32'h010);
        chk("both c1 m_wdata", m_wdata, 32'hDEADBEEF);
        @(negedge clk); cycle_check();
        @(negedge clk); m_rvalid = 1; m_rdata = '0; cycle_check();
        chk("both c3 d_ack", 32'(d_ack), 32'd1);
        chk("both c3 mem_stall", 32'(mem_stall), 32'd0);
        chk("both c3 if_ack", 32'(if_ack), 32'd0);
        @(negedge clk); d_req = 0; m_rvalid = 0; cycle_check();
        chk("both c4 m_req", 32'(m_req), 32'd0);
        @(negedge clk); cycle_check();
        chk("both c5 m_req", 32'(m_req), 32'd1);
        chk("both c5 m_we", 32'(m_we), 32'd0);
        chk("both c5 m_addr", 32'(m_addr), 32'h008);
        @(negedge clk); m_rvalid = 1; m_rdata = 32'h00000013; cycle_check();
        chk("both c6 if_ack", 32'(if_ack), 32'd1);
        @(negedge clk); if_req = 0; m_rvalid = 0; m_rdata = '0; cycle_check();

        // ---- starvation guard: both held, memory latency 1 ----
        auto_mem = 1; lat_min = 1; lat_max = 1; n_grant = 0;
        for (int c = 0; c < 60 && n_grant < 6; c++) begin
            @(negedge clk);
            if (c == 0) begin
                if_req = 1; if_addr = 9'h00C;
                d_req = 1; d_we = 1; d_addr = 9'h030; d_wdata = 32'hCAFE0001; d_funct3 = 3'b010;
            end
            mem_drive();
            cycle_check();
            if (m_req === 1'b1) begin
                got_pat[n_grant] = m_we;
                n_grant++;
            end
        end
        chk("starve grants seen", 32'(n_grant), 32'd6);
        for (int k = 0; k < 6; k++)
            chk($sformatf("starve grant %0d is data", k), 32'(got_pat[k]), 32'(exp_pat[k]));
        for (int c = 0; c < 30 && (c == 0 || mb_busy); c++) begin
            @(negedge clk);
            if (c == 0) begin if_req = 0; d_req = 0; end
            mem_drive();
            cycle_check();
        end

        // ---- timeout in WAIT_D ----
        auto_mem = 0; cd = 0; issue_c = -1; ack_c = -1; ack_rd = 'x;
        for (int c = 0; c < 40 && ack_c < 0; c++) begin
            @(negedge clk);
            if (c == 0) begin
                m_rvalid = 0; m_rdata = '0;
                d_req = 1; d_we = 0; d_addr = 9'h040; d_funct3 = 3'b010;
            end
            cycle_check();
            if (m_req === 1'b1) issue_c = c;
            if (d_ack === 1'b1) begin ack_c = c; ack_rd = d_rdata; end
        end
        chk("timeout ack delay", 32'(ack_c - issue_c), 32'd16);
        chk("timeout d_rdata", ack_rd, 32'd0);
        @(negedge clk); d_req = 0; m_rvalid = 1; m_rdata = 32'hFFFFFFFF; cycle_check();
        chk("stray err", 32'(err), 32'd1);
        chk("stray d_ack", 32'(d_ack), 32'd0);
        @(negedge clk); m_rvalid = 0; m_rdata = '0; cycle_check();
        chk("stray err hold", 32'(err), 32'd1);
        chk("stray m_req", 32'(m_req), 32'd0);

        // ---- reset in WAIT_I, then a late response ----
        @(negedge clk); if_req = 1; if_addr = 9'h0A0; cycle_check();
        @(negedge clk); cycle_check();
        @(negedge clk); reset = 1; cycle_check();
        @(negedge clk); reset = 0; if_req = 0; m_rvalid = 1; m_rdata = 32'hAAAA5555; cycle_check();
        chk("rst-mid if_ack", 32'(if_ack), 32'd0);
        chk("rst-mid if_rdata", if_rdata, 32'd0);
        chk("rst-mid m_addr", 32'(m_addr), 32'd0);
        chk("rst-mid m_funct3", 32'(m_funct3), 32'd0);
        chk("rst-mid err", 32'(err), 32'd0);
        @(negedge clk); m_rvalid = 0; m_rdata = '0; cycle_check();
        chk("rst-mid idle m_req", 32'(m_req), 32'd0);

        // ---- load after store, same address, latency 3 ----
        auto_mem = 1; cd = 0; lat_min = 3; lat_max = 3; phase = 0; mreq_cnt = 0; got_rd = 'x;
        for (int c = 0; c < 60 && phase < 2; c++) begin
            @(negedge clk);
            if (c == 0) begin
                d_req = 1; d_we = 1; d_addr = 9'h020; d_wdata = 32'h12345678; d_funct3 = 3'b010;
            end else if (saw_d_ack && phase == 1) begin
                d_we = 0; d_wdata = '0;
            end
            mem_drive();
            cycle_check();
            if (m_req === 1'b1) mreq_cnt++;
            if (d_ack === 1'b1) begin
                if (phase == 1) got_rd = d_rdata;
                phase++;
            end
        end
        chk("ld-after-st d_rdata", got_rd, 32'h12345678);
        chk("ld-after-st m_req cycles", 32'(mreq_cnt), 32'd2);

        // ---- randomized traffic ----
        stray_en = 1; late_en = 1; lat_min = 1; lat_max = 4;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 299) == 0);
            if (!if_req || saw_if_ack) begin
                if_req  = ($urandom_range(0, 3) != 0);
                if_addr = PC_W'($urandom);
            end
            if (!d_req || saw_d_ack) begin
                d_req    = ($urandom_range(0, 2) != 0);
                d_we     = 1'($urandom_range(0, 1));
                d_addr   = DM_ADDRESS'($urandom_range(0, 31));
                d_wdata  = $urandom;
                d_funct3 = 3'($urandom_range(0, 5));
            end
            mem_drive();
            cycle_check();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
